// File: rtl/jtpopeye_rom_pkg.sv
// Shared types and constants for the Popeye ROM arbiter.
//   - Arbiter FSM state type.
//   - Client index map: CPU, char/background, sprites, sound.
//   - Default bus geometry.
//   - wrap_idx helper for modulo-N index arithmetic.
package jtpopeye_rom_pkg;

    localparam int unsigned ROM_N  = 4;
    localparam int unsigned ROM_AW = 22;
    localparam int unsigned ROM_DW = 32;

    localparam int unsigned CLI_CPU  = 0;
    localparam int unsigned CLI_CHAR = 1;
    localparam int unsigned CLI_OBJ  = 2;
    localparam int unsigned CLI_SND  = 3;

    typedef enum logic [1:0] {
        StIdle,
        StReq,
        StWait
    } arb_state_e;

    // (base + ofs) mod n; n need not be a power of two.
    function automatic int unsigned wrap_idx(int unsigned base, int unsigned ofs,
                                             int unsigned n);
        return (base + ofs) % n;
    endfunction

endpackage

// File: rtl/jtpopeye_rom_pick.sv
// Combinational N-way grant picker for the ROM arbiter.
// Default build: round-robin, the first missing client at or after ptr_i wins.
// With JTPOPEYE_ROMARB_PRIO_EN defined: fixed priority, lowest index wins and
// ptr_i is ignored.
// Ports:
//   miss_i    - per-client miss vector
//   ptr_i     - round-robin start index
//   gnt_oh_o  - one-hot grant
//   gnt_idx_o - index of the granted client
//   any_o     - at least one client was granted
module jtpopeye_rom_pick
    import jtpopeye_rom_pkg::*;
#(
    parameter int unsigned N  = ROM_N,
    parameter int unsigned PW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  miss_i,
    input  logic [PW-1:0] ptr_i,
    output logic [N-1:0]  gnt_oh_o,
    output logic [PW-1:0] gnt_idx_o,
    output logic          any_o
);

    logic [PW-1:0] idx;

`ifdef JTPOPEYE_ROMARB_PRIO_EN
    logic unused_ptr;
    assign unused_ptr = ^ptr_i;
`endif

    always_comb begin
        gnt_oh_o  = '0;
        gnt_idx_o = '0;
        any_o     = 1'b0;
        idx       = '0;
        for (int unsigned k = 0; k < N; k++) begin
`ifdef JTPOPEYE_ROMARB_PRIO_EN
            idx = PW'(k);
`else
            idx = PW'(wrap_idx(32'(ptr_i), k, N));
`endif
            if (!any_o && miss_i[idx]) begin
                any_o         = 1'b1;
                gnt_oh_o[idx] = 1'b1;
                gnt_idx_o     = idx;
            end
        end
    end

endmodule

// File: rtl/jtpopeye_rom_arb.sv
// Shares one SDRAM read port among N ROM clients (CPU, char, sprites, sound).
// Each client owns a one-entry tag/data cache; hits are answered combinationally
// from the registered tag/valid, misses are fetched one at a time.
// Arbitration is round-robin by default; define JTPOPEYE_ROMARB_PRIO_EN for
// fixed priority (client 0, the CPU, always first).
// Ports:
//   clk, rst       - system clock, synchronous active-high reset
//   loop_rst       - frame ROM loop reset, same effect as rst
//   downloading    - ROM download active: no requests, caches invalidated
//   cli_cs/addr    - per-client request and word address (AW bits each)
//   cli_ok/data    - per-client hit flag and cached word (DW bits each)
//   sdram_addr/req - request to the SDRAM controller
//   sdram_ack      - request accepted pulse
//   data_read/rdy  - read data and its valid pulse
//   refresh_en     - arbiter idle with nothing pending, refresh allowed
module jtpopeye_rom_arb
    import jtpopeye_rom_pkg::*;
#(
    parameter int unsigned N  = ROM_N,
    parameter int unsigned AW = ROM_AW,
    parameter int unsigned DW = ROM_DW
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            loop_rst,
    input  logic            downloading,
    input  logic [N-1:0]    cli_cs,
    input  logic [N*AW-1:0] cli_addr,
    output logic [N-1:0]    cli_ok,
    output logic [N*DW-1:0] cli_data,
    output logic [AW-1:0]   sdram_addr,
    output logic            sdram_req,
    input  logic            sdram_ack,
    input  logic [DW-1:0]   data_read,
    input  logic            data_rdy,
    output logic            refresh_en
);

    localparam int unsigned PW = (N > 1) ? $clog2(N) : 1;

    arb_state_e           state_q, state_d;
    logic [N-1:0]         valid_q, valid_d;
    logic [N-1:0][AW-1:0] tag_q, tag_d;
    logic [N-1:0][DW-1:0] data_q, data_d;
    logic [PW-1:0]        ptr_q, ptr_d;
    logic [PW-1:0]        gnt_q, gnt_d;
    logic [AW-1:0]        addr_q, addr_d;
    logic                 req_q, req_d;
    logic                 refresh_q, refresh_d;

    logic [N-1:0]         hit, miss;
    logic [N-1:0]         pick_oh;
    logic [PW-1:0]        pick_idx;
    logic                 pick_any;
    logic [AW-1:0]        gnt_addr;

    for (genvar g = 0; g < N; g++) begin : g_hit
        assign hit[g] = valid_q[g] & (cli_addr[g*AW +: AW] == tag_q[g]);
    end

    assign miss     = cli_cs & ~hit;
    assign cli_ok   = cli_cs & hit;
    assign cli_data = data_q;

    jtpopeye_rom_pick #(
        .N  (N),
        .PW (PW)
    ) u_pick (
        .miss_i    (miss),
        .ptr_i     (ptr_q),
        .gnt_oh_o  (pick_oh),
        .gnt_idx_o (pick_idx),
        .any_o     (pick_any)
    );

    // AND-OR mux of the granted client's address
    always_comb begin
        gnt_addr = '0;
        for (int unsigned i = 0; i < N; i++) begin
            if (pick_oh[i]) gnt_addr = gnt_addr | cli_addr[i*AW +: AW];
        end
    end

    always_comb begin
        state_d   = state_q;
        valid_d   = valid_q;
        tag_d     = tag_q;
        data_d    = data_q;
        ptr_d     = ptr_q;
        gnt_d     = gnt_q;
        addr_d    = addr_q;
        req_d     = req_q;
        refresh_d = refresh_q;

        case (state_q)
            StIdle: begin
                if (downloading) begin
                    valid_d   = '0;
                    refresh_d = 1'b1;
                end else if (pick_any) begin
                    gnt_d     = pick_idx;
                    addr_d    = gnt_addr;
                    req_d     = 1'b1;
                    refresh_d = 1'b0;
                    state_d   = StReq;
                end else begin
                    refresh_d = 1'b1;
                end
            end
            StReq: begin
                if (sdram_ack) begin
                    req_d   = 1'b0;
                    state_d = StWait;
                    // Ack and data in one cycle: fill straight away
                    if (data_rdy) begin
                        tag_d[gnt_q]   = addr_q;
                        data_d[gnt_q]  = data_read;
                        valid_d[gnt_q] = 1'b1;
                        ptr_d          = PW'(wrap_idx(32'(gnt_q), 1, N));
                        state_d        = StIdle;
                    end
                end
            end
            StWait: begin
                // Fill with the latched address even if the client moved on
                if (data_rdy) begin
                    tag_d[gnt_q]   = addr_q;
                    data_d[gnt_q]  = data_read;
                    valid_d[gnt_q] = 1'b1;
                    ptr_d          = PW'(wrap_idx(32'(gnt_q), 1, N));
                    state_d        = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst || loop_rst) begin
            state_q   <= StIdle;
            valid_q   <= '0;
            tag_q     <= '0;
            data_q    <= '0;
            ptr_q     <= '0;
            gnt_q     <= '0;
            addr_q    <= '0;
            req_q     <= 1'b0;
            refresh_q <= 1'b1;
        end else begin
            state_q   <= state_d;
            valid_q   <= valid_d;
            tag_q     <= tag_d;
            data_q    <= data_d;
            ptr_q     <= ptr_d;
            gnt_q     <= gnt_d;
            addr_q    <= addr_d;
            req_q     <= req_d;
            refresh_q <= refresh_d;
        end
    end

    assign sdram_addr = addr_q;
    assign sdram_req  = req_q;
    assign refresh_en = refresh_q;

endmodule

// File: tb/tb_jtpopeye_rom_arb.sv
// Self-checking bench for jtpopeye_rom_arb (default round-robin build).
// Expected SDRAM request addresses are queued by the stimulus; a monitor pops
// and compares them at every accepted request. Cache and status outputs are
// checked against hand-computed values.
module tb_jtpopeye_rom_arb;
    import jtpopeye_rom_pkg::*;

    localparam int N  = 4;
    localparam int AW = 22;
    localparam int DW = 32;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic            loop_rst = 1'b0;
    logic            downloading = 1'b0;
    logic [N-1:0]    cli_cs = '0;
    logic [N*AW-1:0] cli_addr = '0;
    logic [N-1:0]    cli_ok;
    logic [N*DW-1:0] cli_data;
    logic [AW-1:0]   sdram_addr;
    logic            sdram_req;
    logic            sdram_ack = 1'b0;
    logic [DW-1:0]   data_read = '0;
    logic            data_rdy = 1'b0;
    logic            refresh_en;

    jtpopeye_rom_arb #(
        .N  (N),
        .AW (AW),
        .DW (DW)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .loop_rst    (loop_rst),
        .downloading (downloading),
        .cli_cs      (cli_cs),
        .cli_addr    (cli_addr),
        .cli_ok      (cli_ok),
        .cli_data    (cli_data),
        .sdram_addr  (sdram_addr),
        .sdram_req   (sdram_req),
        .sdram_ack   (sdram_ack),
        .data_read   (data_read),
        .data_rdy    (data_rdy),
        .refresh_en  (refresh_en)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;
    logic [AW-1:0] exp_q[$];
    logic [AW-1:0] mon_exp;

    localparam logic [AW-1:0] A1  = 22'h010040;
    localparam logic [AW-1:0] A2  = 22'h020080;
    localparam logic [AW-1:0] A3  = 22'h0300C0;
    localparam logic [AW-1:0] A1B = 22'h010044;

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    // Request monitor: each accepted request must match the next queued address
    always @(negedge clk) begin
        if (sdram_req && sdram_ack) begin
            if (exp_q.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL sdram_addr: unexpected request to %0h", sdram_addr);
            end else begin
                mon_exp = exp_q.pop_front();
                check("sdram_addr", 64'(sdram_addr), 64'(mon_exp));
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_cli(input int i, input logic cs, input logic [AW-1:0] a);
        cli_cs[i]            = cs;
        cli_addr[i*AW +: AW] = a;
    endtask

    task automatic wait_req(input string name);
        int n = 0;
        while (!sdram_req && n < 50) begin
            tick();
            n++;
        end
        check({name, " req seen"}, 64'(sdram_req), 64'd1);
    endtask

    task automatic serve(input int cli, input int ad, input int rd, input logic [DW-1:0] d,
                         input string name);
        wait_req(name);
        repeat (ad) tick();
        sdram_ack = 1'b1;
        tick();
        sdram_ack = 1'b0;
        repeat (rd) tick();
        check({name, " ok before fill"}, 64'(cli_ok[cli]), 64'd0);
        data_rdy  = 1'b1;
        data_read = d;
        tick();
        data_rdy  = 1'b0;
        check({name, " ok"}, 64'(cli_ok[cli]), 64'd1);
        check({name, " data"}, 64'(cli_data[cli*DW +: DW]), 64'(d));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        // Reset state, all clients asserting address 0 (matches reset tag)
        cli_cs = '1;
        tick();
        tick();
        check("reset req", 64'(sdram_req), 64'd0);
        check("reset refresh", 64'(refresh_en), 64'd1);
        check("reset ok", 64'(cli_ok), 64'd0);
        check("reset data", 64'(cli_data == '0), 64'd1);
        cli_cs = '0;
        rst = 1'b0;
        tick();

        // T1: CPU miss, ack after 3 cycles, data 4 cycles after ack
        set_cli(CLI_CPU, 1'b1, 22'h000100);
        exp_q.push_back(22'h000100);
        serve(CLI_CPU, 3, 3, 32'hDEADBEEF, "t1");
        for (int i = 0; i < 4; i++) begin
            check("t1 hit ok", 64'(cli_ok[CLI_CPU]), 64'd1);
            check("t1 hit no req", 64'(sdram_req), 64'd0);
            tick();
        end
        check("t1 refresh", 64'(refresh_en), 64'd1);

        // T2: 1,2,3 miss together with ptr 0; client 1 re-misses after its fill
        cli_cs = '0;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        set_cli(CLI_CHAR, 1'b1, A1);
        set_cli(CLI_OBJ, 1'b1, A2);
        set_cli(CLI_SND, 1'b1, A3);
        exp_q.push_back(A1);
        exp_q.push_back(A2);
        exp_q.push_back(A3);
        exp_q.push_back(A1B);
        serve(CLI_CHAR, 0, 1, 32'h11110001, "t2 c1");
        set_cli(CLI_CHAR, 1'b1, A1B);
        serve(CLI_OBJ, 1, 0, 32'h22220002, "t2 c2");
        serve(CLI_SND, 0, 2, 32'h33330003, "t2 c3");
        serve(CLI_CHAR, 0, 0, 32'h11110004, "t2 c1 again");
        check("t2 all ok", 64'(cli_ok), 64'b1110);

        // T3: client 2 moves address during WAIT
        cli_cs = '0;
        set_cli(CLI_OBJ, 1'b1, 22'h001000);
        exp_q.push_back(22'h001000);
        exp_q.push_back(22'h001004);
        wait_req("t3");
        sdram_ack = 1'b1;
        tick();
        sdram_ack = 1'b0;
        set_cli(CLI_OBJ, 1'b1, 22'h001004);
        check("t3 ok on change", 64'(cli_ok[CLI_OBJ]), 64'd0);
        tick();
        data_rdy  = 1'b1;
        data_read = 32'hAAAA1000;
        tick();
        data_rdy  = 1'b0;
        check("t3 stale ok", 64'(cli_ok[CLI_OBJ]), 64'd0);
        check("t3 stale data", 64'(cli_data[CLI_OBJ*DW +: DW]), 64'h0AAAA1000);
        serve(CLI_OBJ, 0, 0, 32'hAAAA1004, "t3 refetch");

        // T4: ack and data_rdy in the same REQ cycle, then a stray data_rdy
        set_cli(CLI_OBJ, 1'b0, 22'h001004);
        set_cli(CLI_SND, 1'b1, 22'h003000);
        exp_q.push_back(22'h003000);
        wait_req("t4");
        sdram_ack = 1'b1;
        data_rdy  = 1'b1;
        data_read = 32'hCAFEF00D;
        tick();
        sdram_ack = 1'b0;
        data_rdy  = 1'b0;
        check("t4 ok", 64'(cli_ok[CLI_SND]), 64'd1);
        check("t4 data", 64'(cli_data[CLI_SND*DW +: DW]), 64'h0CAFEF00D);
        check("t4 req low", 64'(sdram_req), 64'd0);
        tick();
        check("t4 refresh", 64'(refresh_en), 64'd1);
        data_rdy  = 1'b1;
        data_read = 32'h0BADF00D;
        tick();
        data_rdy  = 1'b0;
        check("t4 stray rdy", 64'(cli_data[CLI_SND*DW +: DW]), 64'h0CAFEF00D);
        check("t4 stray req", 64'(sdram_req), 64'd0);

        // T5: reset during WAIT, data_rdy arrives while reset
        set_cli(CLI_SND, 1'b0, 22'h003000);
        set_cli(CLI_CPU, 1'b1, 22'h000200);
        exp_q.push_back(22'h000200);
        wait_req("t5");
        sdram_ack = 1'b1;
        tick();
        sdram_ack = 1'b0;
        cli_cs = '1;
        rst = 1'b1;
        tick();
        check("t5 req", 64'(sdram_req), 64'd0);
        check("t5 refresh", 64'(refresh_en), 64'd1);
        check("t5 ok", 64'(cli_ok), 64'd0);
        check("t5 data clear", 64'(cli_data == '0), 64'd1);
        data_rdy  = 1'b1;
        data_read = 32'h5555AAAA;
        tick();
        data_rdy  = 1'b0;
        check("t5 not written", 64'(cli_data == '0), 64'd1);
        cli_cs = 4'b0001;
        rst = 1'b0;
        exp_q.push_back(22'h000200);
        serve(CLI_CPU, 0, 0, 32'h12345678, "t5 refetch");

        // T6: download blocks requests and invalidates; refetch afterwards
        downloading = 1'b1;
        set_cli(CLI_CHAR, 1'b1, A1B);
        tick();
        check("t6 invalidated", 64'(cli_ok[CLI_CPU]), 64'd0);
        for (int i = 0; i < 3; i++) begin
            check("t6 no req", 64'(sdram_req), 64'd0);
            check("t6 refresh", 64'(refresh_en), 64'd1);
            tick();
        end
        downloading = 1'b0;
        exp_q.push_back(A1B);
        exp_q.push_back(22'h000200);
        serve(CLI_CHAR, 0, 1, 32'h66660001, "t6 c1");
        serve(CLI_CPU, 1, 0, 32'h66660000, "t6 c0");
        check("t6 both ok", 64'(cli_ok), 64'b0011);

        // loop_rst clears the caches like rst
        loop_rst = 1'b1;
        tick();
        loop_rst = 1'b0;
        check("loop_rst ok", 64'(cli_ok), 64'd0);
        check("loop_rst req", 64'(sdram_req), 64'd0);
        cli_cs = '0;
        tick();

        check("queue drained", 64'(exp_q.size()), 64'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/jtpopeye_rom_arb.md
Name: jtpopeye_rom_arb

Overview:
- Shares the single SDRAM read port among N game ROM clients: main CPU, char/background, sprites and sound.
- The shared port signals are sdram_addr, sdram_req, sdram_ack, data_read, data_rdy, refresh_en and loop_rst.
- Each client has a one-entry tag/data cache, so repeated reads of the same word need no SDRAM access.
- Sits inside jtpopeye_game between the ROM-consuming units and the frame's SDRAM port.

Parameters:
- N, 4, number of clients. Index 0 is the CPU.
- AW, 22, SDRAM word address width.
- DW, 32, SDRAM read data width.

Ports:
- clk  in  1  system clock (40 MHz).
- rst  in  1  synchronous, active-high reset.
- loop_rst  in  1  frame-level ROM loop reset. Acts as a synchronous clear, same effect as rst.
- downloading  in  1  ROM download in progress. While high, no requests are issued and all caches are invalidated.
- cli_cs  in  N  per-client read request. Held high with a stable address until cli_ok.
- cli_addr  in  N*AW  per-client word address. Client i uses bits [i*AW +: AW].
- cli_ok  out  N  per-client data valid for the current address.
- cli_data  out  N*DW  per-client cached word.
- sdram_addr  out  AW  address of the granted request.
- sdram_req  out  1  request to the SDRAM controller.
- sdram_ack  in  1  one-cycle pulse: request accepted.
- data_read  in  DW  SDRAM read data.
- data_rdy  in  1  one-cycle pulse: data_read is valid.
- refresh_en  out  1  high when the arbiter is idle with no pending miss, allowing SDRAM refresh.

Behaviour:
- Reset values (rst or loop_rst): state IDLE, sdram_req=0, sdram_addr=0, refresh_en=1, all valid bits cleared, tags=0, cli_data=0, cli_ok=0, round-robin pointer=0.
- Hit definition, per client i: hit[i] = valid[i] & (cli_addr_i == tag[i]).
- cli_ok[i] = cli_cs[i] & hit[i]. This is combinational from registered tag/valid, so a hit has zero latency.
- cli_data[i] is the registered cached word.
- Address change while cs is high: cli_ok drops in the same cycle, and the access becomes a miss.
- Miss: miss[i] = cli_cs[i] & ~hit[i].
- FSM states: IDLE, REQ, WAIT.
- IDLE:
  - If downloading, stay in IDLE.
  - Else if any miss, grant the first missing client at or after the pointer (round-robin).
  - On grant: latch gnt index and sdram_addr = cli_addr_gnt, set sdram_req=1, refresh_en=0, and go to REQ.
  - No misses: refresh_en=1.
- REQ: hold sdram_req and sdram_addr until sdram_ack. Then sdram_req=0 and go to WAIT.
- WAIT:
  - On data_rdy: tag[gnt]=sdram_addr, cli_data[gnt]=data_read, valid[gnt]=1.
  - Pointer becomes gnt+1 (mod N). Go to IDLE.
  - The earliest cli_ok is the cycle after data_rdy, so miss latency is 2 cycles plus the SDRAM latency.
- sdram_ack and data_rdy in the same cycle while in REQ: treat as both events and fill the cache directly. Next state is IDLE.
- data_rdy outside WAIT: ignored.
- A client dropping cs mid-fetch does not abort the fetch; the cache is still filled.
- A client changing address mid-fetch: the fill uses the latched address, and the client misses again afterwards.
- downloading rising mid-fetch: finish the current transaction, then invalidate all caches and idle.
- rst mid-fetch: sdram_req falls on the next edge, and any subsequent data_rdy is ignored.
- The tag compare is full AW bits. Pointer wrap-around is mod N.

Optional Feature:
- Macro: JTPOPEYE_ROMARB_PRIO_EN.
- Defined: fixed priority, lowest index wins (the CPU is always first), and the pointer is unused.
- Undefined: round-robin as described above.

Decomposition:
- Package jtpopeye_rom_pkg holds:
  - FSM state typedef (IDLE/REQ/WAIT);
  - client index constants CLI_CPU=0, CLI_CHAR=1, CLI_OBJ=2, CLI_SND=3;
  - default AW/DW localparams.
- One sub-module, jtpopeye_rom_pick: combinational N-way round-robin/priority picker taking miss vector and pointer, producing a one-hot grant and its index.

Test Plan:
- Reset then client 0 cs with addr 22'h000100, SDRAM acks after 3 cycles and returns data_rdy with 32'hDEADBEEF 4 cycles later -> sdram_addr=22'h000100, cli_ok[0] high one cycle after data_rdy, cli_data[0]=32'hDEADBEEF. A repeat read of the same address hits with no sdram_req.
- Clients 1, 2 and 3 miss simultaneously with the pointer at 0 -> grants in order 1, 2, 3 (round-robin). With JTPOPEYE_ROMARB_PRIO_EN and client 0 re-missing each time, client 0 is always served first.
- Client 2 changes address from 22'h001000 to 22'h001004 during WAIT -> the fill writes tag 22'h001000, cli_ok[2] stays low, and a second request for 22'h001004 is issued.
- sdram_ack and data_rdy pulse in the same cycle in REQ -> the cache is filled and the FSM reaches IDLE next cycle.
- Assert rst during WAIT, then data_rdy arrives -> sdram_req=0, all cli_ok=0, the cache is not written, refresh_en=1.
- downloading=1 with pending misses -> no sdram_req and refresh_en=1. After downloading falls, previously valid entries miss and are refetched.
